// File: rtl/pad_arb_pkg.sv
// Shared types and constants for the pad-mux arbiter: owner/state encodings,
// per-owner select patterns and requester indices.
package pad_arb_pkg;

  typedef enum logic [1:0] {
    TEST = 2'd0,
    MODA = 2'd1,
    MODB = 2'd2,
    GPIO = 2'd3
  } owner_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SWITCH  = 3'd1,
    SETTLE  = 3'd2,
    GRANT   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam int REQ_TEST = 0;
  localparam int REQ_MODA = 1;
  localparam int REQ_MODB = 2;
  localparam int REQ_GPIO = 3;

  // {test_sel, moda_sel, modb_sel}
  localparam logic [2:0] SEL_TEST = 3'b100;
  localparam logic [2:0] SEL_MODA = 3'b010;
  localparam logic [2:0] SEL_MODB = 3'b001;
  localparam logic [2:0] SEL_GPIO = 3'b000;

  function automatic logic [2:0] sel_of(owner_e o);
    case (o)
      TEST:    return SEL_TEST;
      MODA:    return SEL_MODA;
      MODB:    return SEL_MODB;
      default: return SEL_GPIO;
    endcase
  endfunction

  // Round-robin successor among MODA/MODB/GPIO
  function automatic owner_e rr_next(owner_e o);
    case (o)
      MODA:    return MODB;
      MODB:    return GPIO;
      default: return MODA;
    endcase
  endfunction

endpackage

// File: rtl/padarb_rr_pick.sv
// Combinational 3-way round-robin picker over MODA/MODB/GPIO; search starts
// at the pointer and wraps, winner returned as an owner code (1..3).
module padarb_rr_pick
  import pad_arb_pkg::*;
(
  input  logic [2:0] req_rr,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] base;
  logic [2:0] rot;
  logic [1:0] off;
  logic [2:0] slot;

  assign base = (ptr == 2'd0) ? 2'd0 : ptr - 2'd1;

  // rot[k] is the request of the candidate k places after the pointer
  always_comb begin
    case (base)
      2'd1:    rot = {req_rr[0], req_rr[2], req_rr[1]};
      2'd2:    rot = {req_rr[1], req_rr[0], req_rr[2]};
      default: rot = req_rr;
    endcase
  end

  always_comb begin
    off = 2'd2;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    slot = {1'b0, base} + {1'b0, off};
    if (slot >= 3'd3) slot = slot - 3'd3;
    winner = slot[1:0] + 2'd1;
    valid  = |rot;
  end

endmodule

// File: rtl/pad_mux_arbiter.sv
// Pad-mux sequencer: one-hot pad ownership with guard windows around every
// select change. `define PADARB_PREEMPT_EN lets TEST force the owner off.
//
// state   | meaning
// IDLE    | no grant, pads quiet, selects hold last owner, arbitrate
// SWITCH  | one cycle, selects loaded with the pending owner
// SETTLE  | GUARD_CYCLES quiet cycles before granting
// GRANT   | gnt set, pad_quiet low
// RELEASE | GUARD_CYCLES quiet cycles after ownership ends
module pad_mux_arbiter
  import pad_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       test_sel,
  output logic       moda_sel,
  output logic       modb_sel,
  output logic [1:0] owner,
  output logic       pad_quiet
);

  localparam logic [3:0] GUARD_LOAD = (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);
  localparam logic       GUARD_ZERO = (GUARD_CYCLES == 0);

  state_e     state;
  logic [3:0] guard_cnt;
  owner_e     rr_ptr;
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic       arb_hit;
  owner_e     arb_owner;
  logic       owner_req;
  logic       preempt;

  padarb_rr_pick u_pick (
    .req_rr (req[3:1]),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign arb_hit   = req[REQ_TEST] | pick_valid;
  assign arb_owner = req[REQ_TEST] ? TEST : owner_e'(pick_idx);
  assign owner_req = req[owner];

`ifdef PADARB_PREEMPT_EN
  assign preempt = req[REQ_TEST] && (owner != TEST);
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= GPIO;
      {test_sel, moda_sel, modb_sel} <= SEL_GPIO;
      pad_quiet <= 1'b1;
      rr_ptr    <= MODA;
      guard_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            state <= SWITCH;
            owner <= arb_owner;
            {test_sel, moda_sel, modb_sel} <= sel_of(arb_owner);
          end
        end
        SWITCH, SETTLE: begin
          if (!owner_req) begin
            // winner gave up before the grant: rr pointer untouched
            state     <= GUARD_ZERO ? IDLE : RELEASE;
            guard_cnt <= GUARD_LOAD;
          end else if ((state == SWITCH && GUARD_ZERO) ||
                       (state == SETTLE && guard_cnt == 4'd0)) begin
            state     <= GRANT;
            gnt       <= 4'b0001 << owner;
            pad_quiet <= 1'b0;
            if (owner != TEST) rr_ptr <= rr_next(owner_e'(owner));
          end else if (state == SWITCH) begin
            state     <= SETTLE;
            guard_cnt <= GUARD_LOAD;
          end else begin
            guard_cnt <= guard_cnt - 4'd1;
          end
        end
        GRANT: begin
          if (!owner_req || preempt) begin
            state     <= GUARD_ZERO ? IDLE : RELEASE;
            guard_cnt <= GUARD_LOAD;
            gnt       <= '0;
            pad_quiet <= 1'b1;
          end
        end
        RELEASE: begin
          if (guard_cnt == 4'd0) state <= IDLE;
          else                   guard_cnt <= guard_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_mux_arbiter.sv
// Bench for pad_mux_arbiter: three instances (GUARD_CYCLES 0, 2, 3) share one
// request stream and are compared every cycle against a timestamp-based model.
module tb_pad_mux_arbiter;

  localparam int NDUT = 3;
`ifdef PADARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  function automatic int guard_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt_w      [NDUT];
  logic       test_sel_w [NDUT];
  logic       moda_sel_w [NDUT];
  logic       modb_sel_w [NDUT];
  logic [1:0] owner_w    [NDUT];
  logic       quiet_w    [NDUT];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    pad_mux_arbiter #(.GUARD_CYCLES((i == 0) ? 0 : ((i == 1) ? 2 : 3))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt_w[i]),
      .test_sel  (test_sel_w[i]),
      .moda_sel  (moda_sel_w[i]),
      .modb_sel  (modb_sel_w[i]),
      .owner     (owner_w[i]),
      .pad_quiet (quiet_w[i])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Model: an arbitration at edge a gives selects after a, the grant after
  // edge a+1+G (if the winner's req survives), and a release at edge m makes
  // the arbiter free to arbitrate again at edge m+G+1.
  int         m_active  [NDUT];
  int         m_granted [NDUT];
  int         m_arb     [NDUT];
  int         m_gedge   [NDUT];
  int         m_free_at [NDUT];
  int         m_own     [NDUT];
  int         m_rr      [NDUT];
  logic [3:0] x_gnt     [NDUT];
  bit         x_quiet   [NDUT];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_active[d]  = 0;
      m_granted[d] = 0;
      m_arb[d]     = 0;
      m_gedge[d]   = 0;
      m_free_at[d] = 0;
      m_own[d]     = 3;
      m_rr[d]      = 1;
      x_gnt[d]     = 4'b0000;
      x_quiet[d]   = 1'b1;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r);
    int  g;
    bit  own_req;
    int  w;
    g       = guard_of(d);
    own_req = ((r >> m_own[d]) & 4'd1) != 4'd0;
    if (m_granted[d] != 0) begin
      if (!own_req || (PREEMPT && r[0] && m_own[d] != 0)) begin
        m_granted[d] = 0;
        m_active[d]  = 0;
        x_gnt[d]     = 4'b0000;
        x_quiet[d]   = 1'b1;
        m_free_at[d] = edge_n + g + 1;
      end
    end else if (m_active[d] != 0) begin
      if (!own_req) begin
        m_active[d]  = 0;
        m_free_at[d] = edge_n + g + 1;
      end else if (edge_n == m_arb[d] + 1 + g) begin
        m_granted[d] = 1;
        m_gedge[d]   = edge_n;
        x_gnt[d]     = 4'b0001 << m_own[d];
        x_quiet[d]   = 1'b0;
        if (m_own[d] != 0) m_rr[d] = (m_own[d] % 3) + 1;
      end
    end else if (edge_n >= m_free_at[d] && r != 4'b0000) begin
      w = -1;
      if (r[0]) w = 0;
      else begin
        for (int k = 0; k < 3; k++) begin
          int cand;
          cand = ((m_rr[d] - 1 + k) % 3) + 1;
          if (w < 0 && ((r >> cand) & 4'd1) != 4'd0) w = cand;
        end
      end
      m_own[d]    = w;
      m_active[d] = 1;
      m_arb[d]    = edge_n;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check_val($sformatf("%s gnt[g%0d]", tag, guard_of(d)), 32'(gnt_w[d]), 32'(x_gnt[d]));
      check_val($sformatf("%s owner[g%0d]", tag, guard_of(d)), 32'(owner_w[d]), 32'(m_own[d]));
      check_val($sformatf("%s test_sel[g%0d]", tag, guard_of(d)), 32'(test_sel_w[d]), 32'(m_own[d] == 0));
      check_val($sformatf("%s moda_sel[g%0d]", tag, guard_of(d)), 32'(moda_sel_w[d]), 32'(m_own[d] == 1));
      check_val($sformatf("%s modb_sel[g%0d]", tag, guard_of(d)), 32'(modb_sel_w[d]), 32'(m_own[d] == 2));
      check_val($sformatf("%s pad_quiet[g%0d]", tag, guard_of(d)), 32'(quiet_w[d]), 32'(x_quiet[d]));
    end
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    edge_n++;
    for (int d = 0; d < NDUT; d++) model_step(d, r);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [3:0] r;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    for (int c = 0; c < 8; c++) step(4'b0000, "idle");
    for (int c = 0; c < 8; c++) step(4'b0010, "moda");
    for (int c = 0; c < 6; c++) step(4'b0000, "moda_rel");

    // MODA/MODB/GPIO held; the middle instance's owner drops 5 cycles after grant
    for (int c = 0; c < 80; c++) begin
      r = 4'b1110;
      if (c >= 50) r[0] = 1'b1;
      if (m_granted[1] != 0 && (edge_n + 1 - m_gedge[1]) >= 5)
        r = r & ~(4'b0001 << m_own[1]);
      step(r, "rr");
    end
    for (int c = 0; c < 10; c++) step(4'b0000, "rr_rel");

    for (int c = 0; c < 14; c++) step(4'b0100, "modb");
    for (int c = 0; c < 20; c++) step(4'b0101, "preempt");
    for (int c = 0; c < 10; c++) step(4'b0001, "test");
    for (int c = 0; c < 10; c++) step(4'b0000, "test_rel");

    for (int c = 0; c < 3; c++) step(4'b1000, "abandon");
    for (int c = 0; c < 10; c++) step(4'b0000, "abandon_rel");
    for (int c = 0; c < 20; c++) step(4'b0110, "after_abandon");
    for (int c = 0; c < 8; c++) step(4'b0000, "idle2");

    // asynchronous reset in the middle of a grant
    for (int c = 0; c < 12; c++) step(4'b0100, "pre_rst");
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) step(4'b0000, "post_rst");

    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 1; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r = r ^ (4'b0001 << b);
      if ($urandom_range(0, 23) == 0) r = r ^ 4'b0001;
      step(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
